// File: rtl/cordic_phase_gen_mc.sv
// Multi-channel phase generator feeding the CORDIC rotator.
// Per-channel tick dividers and phase accumulators, round-robin onto one stream.
//
// Ports:
//   clock, resetn    rising-edge clock, async active-low reset
//   sync_clr         clears phases, counters, pending, overrun, output (keeps cfg)
//   cfg_we/ch/div/step  shadow config write (div=0 disables channel)
//   out_valid/ready  output handshake
//   out_ch, angle    served channel and its phase
//   x_start, y_start CORDIC seed (AMP while valid, else 0) and 0
//   overrun          sticky per-channel lost-tick flags
module cordic_phase_gen_mc #(
  parameter int WIDTH     = 12,
  parameter int CH        = 4,
  parameter int DIV_WIDTH = 18,
  parameter int AMP       = 1215,
  parameter int CH_W      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 sync_clr,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0]     cfg_step,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_ch,
  output logic [WIDTH-1:0]     angle,
  output logic [WIDTH-1:0]     x_start,
  output logic [WIDTH-1:0]     y_start,
  output logic [CH-1:0]        overrun
);

  logic [DIV_WIDTH-1:0] r_sh_div [CH];
  logic [WIDTH-1:0]     r_sh_step[CH];
  logic [DIV_WIDTH-1:0] r_div    [CH];
  logic [WIDTH-1:0]     r_step   [CH];
  logic [DIV_WIDTH-1:0] r_cnt    [CH];
  logic [WIDTH-1:0]     r_phase  [CH];
  logic [CH-1:0]        r_pend;
  logic [CH-1:0]        r_ovr;
  logic [CH_W-1:0]      r_ptr;
  logic                 r_valid;
  logic [CH_W-1:0]      r_och;
  logic [WIDTH-1:0]     r_angle;
  logic [WIDTH-1:0]     r_xs;

  logic [CH-1:0]        w_wrap;
  logic [CH-1:0]        w_srv;
  logic                 w_load;
  logic                 w_found;
  logic [CH_W-1:0]      w_sel;
  logic [CH_W-1:0]      w_ptr_nx;

  always_comb begin
    w_wrap = '0;
    for (int i = 0; i < CH; i++)
      w_wrap[i] = (r_div[i] != '0) && (r_cnt[i] == r_div[i]);
  end

  // Round-robin: scan from r_ptr (one past last served), wrapping at CH.
  always_comb begin
    int k;
    k       = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < CH; i++) begin
      k = int'(r_ptr) + i;
      if (k >= CH) k = k - CH;
      if (!w_found && r_pend[k]) begin
        w_found = 1'b1;
        w_sel   = CH_W'(k);
      end
    end
  end

  assign w_load   = !r_valid || out_ready;
  assign w_ptr_nx = (w_sel == CH_W'(CH - 1)) ? '0 : w_sel + 1'b1;

  always_comb begin
    w_srv = '0;
    for (int i = 0; i < CH; i++)
      w_srv[i] = w_load && w_found && (w_sel == CH_W'(i));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CH; i++) begin
        r_sh_div[i]  <= '0;
        r_sh_step[i] <= '0;
        r_div[i]     <= '0;
        r_step[i]    <= '0;
        r_cnt[i]     <= '0;
        r_phase[i]   <= '0;
      end
      r_pend <= '0;
      r_ovr  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (cfg_we && cfg_ch == CH_W'(i)) begin
          r_sh_div[i]  <= cfg_div;
          r_sh_step[i] <= cfg_step;
        end
        if (sync_clr) begin
          r_cnt[i]   <= '0;
          r_phase[i] <= '0;
          r_pend[i]  <= 1'b0;
          r_ovr[i]   <= 1'b0;
        end else begin
          // Active cfg only changes at a period boundary or while disabled.
          if (r_div[i] == '0 || w_wrap[i]) begin
            r_div[i]  <= r_sh_div[i];
            r_step[i] <= r_sh_step[i];
          end
          if (w_wrap[i]) begin
            r_cnt[i]   <= '0;
            r_phase[i] <= r_phase[i] + r_step[i];
            r_pend[i]  <= 1'b1;
            if (r_pend[i] && !w_srv[i]) r_ovr[i] <= 1'b1;
          end else begin
            if (r_div[i] == '0) r_cnt[i] <= '0;
            else                r_cnt[i] <= r_cnt[i] + DIV_WIDTH'(1);
            if (w_srv[i]) r_pend[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_och   <= '0;
      r_angle <= '0;
      r_xs    <= '0;
      r_ptr   <= '0;
    end else if (sync_clr) begin
      r_valid <= 1'b0;
      r_och   <= '0;
      r_angle <= '0;
      r_xs    <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_och   <= w_sel;
        r_angle <= r_phase[w_sel];
        r_xs    <= WIDTH'(AMP);
        r_ptr   <= w_ptr_nx;
      end else begin
        r_valid <= 1'b0;
        r_xs    <= '0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_ch    = r_och;
  assign angle     = r_angle;
  assign x_start   = r_xs;
  assign y_start   = '0;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_cordic_phase_gen_mc.sv
// Directed bench for cordic_phase_gen_mc.
// Hand-derived edge timelines; all checks via chk().
module tb_cordic_phase_gen_mc;

  logic        clock;
  logic        resetn;
  logic        sync_clr;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [17:0] cfg_div;
  logic [11:0] cfg_step;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
  logic [11:0] angle;
  logic [11:0] x_start;
  logic [11:0] y_start;
  logic [3:0]  overrun;

  logic        b_cfg_we;
  logic [1:0]  b_cfg_ch;
  logic        b_out_valid;
  logic [1:0]  b_out_ch;
  logic [11:0] b_angle;
  logic [11:0] b_x_start;
  logic [11:0] b_y_start;
  logic [2:0]  b_overrun;
  logic        b_seen;

  int n_tot = 0;
  int n_bad = 0;
  int c;

  cordic_phase_gen_mc u_dut (
    .clock(clock), .resetn(resetn), .sync_clr(sync_clr),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_step(cfg_step),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .angle(angle),
    .x_start(x_start), .y_start(y_start),
    .overrun(overrun)
  );

  cordic_phase_gen_mc #(.CH(3)) u_dut3 (
    .clock(clock), .resetn(resetn), .sync_clr(1'b0),
    .cfg_we(b_cfg_we), .cfg_ch(b_cfg_ch),
    .cfg_div(18'd1), .cfg_step(12'd1),
    .out_valid(b_out_valid), .out_ready(1'b1),
    .out_ch(b_out_ch), .angle(b_angle),
    .x_start(b_x_start), .y_start(b_y_start),
    .overrun(b_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or negedge resetn)
    if (!resetn)         b_seen <= 1'b0;
    else if (b_out_valid) b_seen <= 1'b1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_wr(input logic [1:0] ch,
                        input logic [17:0] dv,
                        input logic [11:0] st);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_div  = dv;
    cfg_step = st;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    sync_clr  = 1'b0;
    cfg_we    = 1'b0;
    b_cfg_we  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    resetn    = 1'b1;
  endtask

  task automatic wait_word(input int lim, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!out_valid && cyc < lim);
    if (!out_valid) chk("timeout", {31'd0, out_valid}, 1);
  endtask

  initial begin
    resetn    = 1'b0;
    sync_clr  = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_step  = '0;
    out_ready = 1'b0;
    b_cfg_we  = 1'b0;
    b_cfg_ch  = '0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_angle", {20'd0, angle}, 0);
    chk("rst_xs", {20'd0, x_start}, 0);
    chk("rst_ovr", {28'd0, overrun}, 0);
    chk("rst_ys", {20'd0, y_start}, 0);

    // basic ticking, div=3
    do_reset();
    cfg_wr(2'd0, 18'd3, 12'h07F);
    wait_word(20, c);
    chk("t1_a0", {20'd0, angle}, 32'h07F);
    chk("t1_ch", {30'd0, out_ch}, 0);
    chk("t1_xs", {20'd0, x_start}, 1215);
    wait_word(20, c);
    chk("t1_a1", {20'd0, angle}, 32'h0FE);
    chk("t1_gap1", c, 4);
    wait_word(20, c);
    chk("t1_a2", {20'd0, angle}, 32'h17D);
    chk("t1_gap2", c, 4);
    tick();
    chk("t1_idle_v", {31'd0, out_valid}, 0);
    chk("t1_idle_xs", {20'd0, x_start}, 0);

    // phase wraps modulo 2^12
    do_reset();
    cfg_wr(2'd0, 18'd3, 12'h800);
    wait_word(20, c);
    chk("t2_a0", {20'd0, angle}, 32'h800);
    wait_word(20, c);
    chk("t2_a1", {20'd0, angle}, 32'h000);
    wait_word(20, c);
    chk("t2_a2", {20'd0, angle}, 32'h800);
    chk("t2_ovr", {28'd0, overrun}, 0);

    // four channels, round robin at full rate
    do_reset();
    for (int k = 0; k < 4; k++) cfg_wr(2'(k), 18'd1, 12'd1);
    wait_word(20, c);
    chk("t3_ch0", {30'd0, out_ch}, 0);
    for (int i = 1; i < 8; i++) begin
      wait_word(4, c);
      chk($sformatf("t3_ch%0d", i), {30'd0, out_ch}, i % 4);
      chk($sformatf("t3_gap%0d", i), c, 1);
    end

    // backpressure: word held, overrun set, latest phase on release
    do_reset();
    out_ready = 1'b0;
    cfg_wr(2'd1, 18'd1, 12'd1);
    repeat (12) tick();
    chk("t4_valid", {31'd0, out_valid}, 1);
    chk("t4_ch", {30'd0, out_ch}, 1);
    chk("t4_hold", {20'd0, angle}, 1);
    chk("t4_ovr", {28'd0, overrun}, 32'b0010);
    out_ready = 1'b1;
    tick();
    chk("t4_rel0", {20'd0, angle}, 5);
    tick();
    chk("t4_rel1", {20'd0, angle}, 6);

    // shadow cfg applied at wrap; last write wins; bad channel ignored
    do_reset();
    b_cfg_we = 1'b1;
    b_cfg_ch = 2'd3;
    cfg_wr(2'd0, 18'd3, 12'd1);
    b_cfg_we = 1'b0;
    wait_word(20, c);
    chk("t5_a0", {20'd0, angle}, 1);
    cfg_wr(2'd0, 18'd5, 12'd1);
    cfg_wr(2'd0, 18'd9, 12'd1);
    wait_word(20, c);
    chk("t5_gap0", c, 2);
    chk("t5_a1", {20'd0, angle}, 2);
    wait_word(20, c);
    chk("t5_gap1", c, 10);
    chk("t5_a2", {20'd0, angle}, 3);
    wait_word(20, c);
    chk("t5_gap2", c, 10);
    chk("t5_a3", {20'd0, angle}, 4);
    chk("t5_badch", {31'd0, b_seen}, 0);
    b_cfg_we = 1'b1;
    b_cfg_ch = 2'd2;
    tick();
    b_cfg_we = 1'b0;
    repeat (6) tick();
    chk("t5_goodch", {31'd0, b_seen}, 1);

    // async reset mid-stream
    do_reset();
    cfg_wr(2'd0, 18'd1, 12'd1);
    wait_word(20, c);
    chk("t6_pre", {31'd0, out_valid}, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_valid", {31'd0, out_valid}, 0);
    chk("t6_angle", {20'd0, angle}, 0);
    chk("t6_xs", {20'd0, x_start}, 0);
    tick();
    resetn = 1'b1;

    // sync_clr keeps cfg, clears phase and overrun
    out_ready = 1'b0;
    cfg_wr(2'd0, 18'd1, 12'd3);
    repeat (12) tick();
    chk("t6_ovr_set", {28'd0, overrun}, 32'b0001);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    chk("t6_sc_valid", {31'd0, out_valid}, 0);
    chk("t6_sc_ovr", {28'd0, overrun}, 0);
    chk("t6_sc_angle", {20'd0, angle}, 0);
    out_ready = 1'b1;
    wait_word(20, c);
    chk("t6_sc_gap0", c, 3);
    chk("t6_sc_a0", {20'd0, angle}, 3);
    wait_word(20, c);
    chk("t6_sc_gap1", c, 2);
    chk("t6_sc_a1", {20'd0, angle}, 6);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
